// File: rtl/hbridge_pwm_gen.sv
// hbridge_pwm_gen: triangle-carrier PWM for one H-bridge cell with double-buffered
// per-leg compares and a minimum leg pulse width.
`default_nettype none

module hbridge_pwm_gen #(
  parameter int            CW        = 16,
  parameter logic [CW-1:0] PERIOD    = 16'd5000,
  parameter logic [CW-1:0] MIN_PULSE = 16'd600
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [CW-1:0] cmp_l,
  input  logic [CW-1:0] cmp_r,
  output logic [1:0]    reg_igbt,
  output logic [CW-1:0] carrier,
  output logic          zero_pulse,
  output logic          peak_pulse,
  output logic          cmd_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc, cnt_dec;

  // Leg index 1 is the left leg, 0 the right leg.
  logic [1:0][CW-1:0] act_q, act_d;
  logic [1:0][CW-1:0] shd_q, shd_d;
  logic [1:0][CW-1:0] hold_q, hold_d;
  logic [1:0][CW-1:0] cmd_clamped;
  logic [1:0]         out_q, out_d;
  logic [1:0]         raw;
  logic               pend_q, pend_d;
  logic               err_q, err_d;
  logic               accept, load;

  assign cnt_inc = cnt_q + CW'(1);
  assign cnt_dec = cnt_q - CW'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!start) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_UP;
          cnt_d   = '0;
        end
        S_UP: begin
          cnt_d = cnt_inc;
          if (cnt_inc == PERIOD) state_d = S_DOWN;
        end
        S_DOWN: begin
          cnt_d = cnt_dec;
          if (cnt_dec == '0) state_d = S_UP;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign carrier    = cnt_q;
  assign zero_pulse = (state_q != S_IDLE) && (cnt_q == '0);
  assign peak_pulse = (state_q != S_IDLE) && (cnt_q == PERIOD);
  assign cmd_ready  = !pend_q;
  assign cmd_err    = err_q;
  assign reg_igbt   = out_q;

  assign cmd_clamped[1] = (cmp_l > PERIOD) ? PERIOD : cmp_l;
  assign cmd_clamped[0] = (cmp_r > PERIOD) ? PERIOD : cmp_r;

  // Accept and load are mutually exclusive because ready is the inverse of pend.
  assign accept = cmd_valid && !pend_q;
  assign load   = pend_q && (zero_pulse || peak_pulse);

  always_comb begin
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    err_d  = err_q;
    if (load) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end else if (accept) begin
      shd_d  = cmd_clamped;
      pend_d = 1'b1;
      if ((cmp_l > PERIOD) || (cmp_r > PERIOD)) err_d = 1'b1;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_leg
    logic [CW-1:0] hold_inc;

    assign raw[g]      = (cnt_q < act_q[g]) || (act_q[g] == PERIOD);
    assign hold_inc    = (hold_q[g] == MIN_PULSE) ? MIN_PULSE : hold_q[g] + CW'(1);

    // hold_q counts clocks since the last edge excluding the current one, so a
    // change is allowed once the level will have been held MIN_PULSE clocks.
    always_comb begin
      out_d[g]  = out_q[g];
      hold_d[g] = hold_inc;
      if (!start) begin
        out_d[g]  = 1'b0;
        hold_d[g] = MIN_PULSE;
      end else if ((hold_inc == MIN_PULSE) && (raw[g] != out_q[g])) begin
        out_d[g]  = raw[g];
        hold_d[g] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_q  <= '0;
      shd_q  <= '0;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
      out_q  <= 2'b00;
      hold_q <= {MIN_PULSE, MIN_PULSE};
    end else begin
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      err_q  <= err_d;
      out_q  <= out_d;
      hold_q <= hold_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hbridge_pwm_gen.sv
// tb_hbridge_pwm_gen: directed scenarios plus random stimulus against a
// phase/timestamp reference model of the H-bridge PWM generator.
`default_nettype none

module tb_hbridge_pwm_gen;

  localparam int CW  = 16;
  localparam int PER = 100;
  localparam int MINP = 10;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW-1:0] cmp_l, cmp_r;
  logic [1:0]    reg_igbt;
  logic [CW-1:0] carrier;
  logic          zero_pulse, peak_pulse, cmd_err;

  hbridge_pwm_gen #(
    .CW(CW), .PERIOD(16'(PER)), .MIN_PULSE(16'(MINP))
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmp_l(cmp_l), .cmp_r(cmp_r), .reg_igbt(reg_igbt),
    .carrier(carrier), .zero_pulse(zero_pulse), .peak_pulse(peak_pulse),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: carrier as a phase within a 2*PER period, leg hold rule as
  // a timestamp of the last output change.
  bit m_run = 0;
  int m_p = 0;
  int m_act[2] = '{0, 0};
  int m_shd[2] = '{0, 0};
  bit m_pend = 0;
  bit m_err = 0;
  bit m_out[2] = '{0, 0};
  int m_chg[2] = '{-MINP, -MINP};
  int m_cyc = 0;

  function automatic int m_cnt();
    if (!m_run) return 0;
    return (m_p <= PER) ? m_p : 2 * PER - m_p;
  endfunction

  function automatic int clampv(input int v);
    return (v > PER) ? PER : v;
  endfunction

  int  t_c;
  bit  t_edge, t_pend;
  bit  t_raw[2];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_run = 0; m_p = 0; m_pend = 0; m_err = 0; m_cyc = 0;
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 0; m_shd[i] = 0; m_out[i] = 0; m_chg[i] = -MINP;
      end
    end else begin
      m_cyc++;
      t_c    = m_cnt();
      t_edge = m_run && (t_c == 0 || t_c == PER);
      t_pend = m_pend;
      for (int i = 0; i < 2; i++) t_raw[i] = (t_c < m_act[i]) || (m_act[i] == PER);
      for (int i = 0; i < 2; i++) begin
        if (!start) begin
          m_out[i] = 0;
          m_chg[i] = m_cyc - MINP;
        end else if (t_raw[i] != m_out[i] && (m_cyc - m_chg[i]) >= MINP) begin
          m_out[i] = t_raw[i];
          m_chg[i] = m_cyc;
        end
      end
      if (t_pend && t_edge) begin
        m_act[1] = m_shd[1]; m_act[0] = m_shd[0]; m_pend = 0;
      end else if (cmd_valid && !t_pend) begin
        m_shd[1] = clampv(int'(cmp_l)); m_shd[0] = clampv(int'(cmp_r));
        m_pend = 1;
        if (int'(cmp_l) > PER || int'(cmp_r) > PER) m_err = 1;
      end
      if (!start) begin
        m_run = 0; m_p = 0;
      end else if (!m_run) begin
        m_run = 1; m_p = 0;
      end else begin
        m_p = (m_p + 1) % (2 * PER);
      end
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("carrier",   32'(carrier),    32'(m_cnt()));
      check_eq("zero",      32'(zero_pulse), 32'(m_run && m_cnt() == 0));
      check_eq("peak",      32'(peak_pulse), 32'(m_run && m_cnt() == PER));
      check_eq("cmd_ready", 32'(cmd_ready),  32'(!m_pend));
      check_eq("reg_igbt",  32'(reg_igbt),   32'({m_out[1], m_out[0]}));
      check_eq("cmd_err",   32'(cmd_err),    32'(m_err));
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int l, input int r);
    int k = 0;
    while (!cmd_ready && k < 400) begin @(negedge clk); k++; end
    if (k >= 400) check_eq("ready_timeout", 32'(cmd_ready), 32'd1);
    cmp_l = 16'(l); cmp_r = 16'(r); cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int k;
    rstn = 1'b1; start = 1'b0; cmd_valid = 1'b0; cmp_l = '0; cmp_r = '0;
    #1 rstn = 1'b0;
    chk_en = 1;
    run(3);
    rstn = 1'b1;
    run(50);

    // Duty 40/60, loaded at the first zero after start.
    send(40, 60);
    start = 1'b1;
    run(600);

    // Double buffer: write at cnt=30 on the up ramp, then a rejected offer.
    k = 0;
    while (!(m_run && m_p == 30) && k < 400) begin @(negedge clk); k++; end
    if (k >= 400) check_eq("cnt30_timeout", 32'(m_p), 32'd30);
    cmp_l = 16'd70; cmp_r = 16'd60; cmd_valid = 1'b1;
    @(negedge clk);
    cmp_l = 16'd20; cmp_r = 16'd20;
    run(5);
    cmd_valid = 1'b0;
    run(400);

    // Clamp to full scale and zero duty; error stays sticky.
    send(150, 0);
    run(400);
    send(50, 50);
    run(300);

    // Short pulse stretched to the minimum width, then abort mid-pulse.
    send(3, 97);
    run(600);
    k = 0;
    while (!m_out[1] && k < 400) begin @(negedge clk); k++; end
    if (k >= 400) check_eq("pulse_timeout", 32'(m_out[1]), 32'd1);
    run(3);
    start = 1'b0;
    run(20);
    start = 1'b1;
    run(300);

    // Random traffic with occasional start drops and out-of-range values.
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom % 8) == 0;
      cmp_l = 16'($urandom_range(0, 110));
      cmp_r = 16'($urandom_range(0, 110));
      start = ($urandom % 400) != 0;
      @(negedge clk);
    end
    start = 1'b0;
    cmd_valid = 1'b0;
    run(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
